// File: rtl/simd_fetcher.sv
// simd_fetcher: single-request instruction fetch with valid/ready handshake
// and a bounded wait that turns a hung memory access into a forced RET.
`ifndef SIMD_FETCH
`define SIMD_FETCH 3'b001
`endif
`ifndef SIMD_DECODE
`define SIMD_DECODE 3'b010
`endif
`ifndef OP_RET
`define OP_RET 4'b1111
`endif

module simd_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [2:0]                       simd_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]     mem_read_data,
  output logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic [1:0]                       fetcher_state,
  output logic                             fetch_error
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, DONE = 2'd2} state_t;
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [INSTRUCTION_WIDTH-1:0] RET_WORD = {`OP_RET, {(INSTRUCTION_WIDTH-4){1'b0}}};
  state_t state;
  logic [15:0] wait_count;
  assign fetcher_state = state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
      instruction <= '0;
      fetch_error <= 1'b0;
      wait_count <= '0;
    end else if (enable) begin
      case (state)
        IDLE: if (simd_state == `SIMD_FETCH) begin
          mem_read_address <= pc;
          mem_read_valid <= 1'b1;
          wait_count <= '0;
          fetch_error <= 1'b0;
          state <= REQUEST;
        end
        // ready has priority over an abort landing in the same cycle
        REQUEST: if (mem_read_ready) begin
          instruction <= mem_read_data;
          mem_read_valid <= 1'b0;
          state <= DONE;
        end else if (wait_count == LAST_WAIT) begin
          instruction <= RET_WORD;
          mem_read_valid <= 1'b0;
          fetch_error <= 1'b1;
          state <= DONE;
        end else begin
          wait_count <= wait_count + 16'd1;
        end
        DONE: if (simd_state == `SIMD_DECODE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simd_fetcher.sv
// tb_simd_fetcher: table vectors, hand-written corner sequences and a
// randomized run checked against a transaction-level fetch model.
module tb_simd_fetcher;
  localparam int TO = 8;
  localparam logic [2:0] F = 3'b001, D = 3'b010, X = 3'b000;
  localparam logic [31:0] RET_WORD = 32'hF000_0000;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, mem_read_ready = 1'b0;
  logic [2:0] simd_state = 3'b0;
  logic [7:0] pc = 8'h0;
  logic [31:0] mem_read_data = 32'h0;
  logic mem_read_valid, fetch_error;
  logic [7:0] mem_read_address;
  logic [31:0] instruction;
  logic [1:0] fetcher_state;

  simd_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .INSTRUCTION_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .simd_state(simd_state), .pc(pc),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .instruction(instruction), .fetcher_state(fetcher_state), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Transaction model: phase 0 waiting for fetch, 1 request outstanding, 2 word delivered.
  int m_phase = 0, m_waited = 0;
  logic [7:0] m_addr = 8'h0;
  logic [31:0] m_instr = 32'h0;
  logic m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic v, input logic [7:0] a,
                         input logic [31:0] i, input logic e);
    chk({tag, ".state"}, 64'(fetcher_state), 64'(s));
    chk({tag, ".valid"}, 64'(mem_read_valid), 64'(v));
    chk({tag, ".addr"}, 64'(mem_read_address), 64'(a));
    chk({tag, ".instr"}, 64'(instruction), 64'(i));
    chk({tag, ".err"}, 64'(fetch_error), 64'(e));
  endtask

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_addr = 8'h0; m_instr = 32'h0; m_err = 1'b0;
  endtask

  // Drive at negedge, let the edge happen, advance the model, return at the next negedge.
  task automatic step(input logic e, input logic [2:0] s, input logic [7:0] p, input logic r,
                      input logic [31:0] d);
    enable = e; simd_state = s; pc = p; mem_read_ready = r; mem_read_data = d;
    @(posedge clk);
    if (e) begin
      if (m_phase == 0 && s == F) begin
        m_phase = 1; m_addr = p; m_waited = 0; m_err = 1'b0;
      end else if (m_phase == 1) begin
        if (r) begin
          m_instr = d; m_phase = 2;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_instr = RET_WORD; m_err = 1'b1; m_phase = 2;
          end
        end
      end else if (m_phase == 2 && s == D) m_phase = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic en; logic [2:0] st; logic [7:0] pc; logic rdy; logic [31:0] data;
    logic [1:0] e_state; logic e_valid; logic [7:0] e_addr; logic [31:0] e_instr; logic e_err;
  } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, F, 8'h05, 1'b0, 32'h0,         2'd1, 1'b1, 8'h05, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, X, 8'h05, 1'b1, 32'hA1234567,  2'd2, 1'b0, 8'h05, 32'hA1234567,  1'b0};
    vecs[2]  = '{1'b1, X, 8'h33, 1'b1, 32'hDEADBEEF,  2'd2, 1'b0, 8'h05, 32'hA1234567,  1'b0};
    vecs[3]  = '{1'b1, D, 8'h33, 1'b0, 32'h0,         2'd0, 1'b0, 8'h05, 32'hA1234567,  1'b0};
    vecs[4]  = '{1'b1, X, 8'h44, 1'b1, 32'h11111111,  2'd0, 1'b0, 8'h05, 32'hA1234567,  1'b0};
    vecs[5]  = '{1'b1, F, 8'h10, 1'b0, 32'h0,         2'd1, 1'b1, 8'h10, 32'hA1234567,  1'b0};
    vecs[6]  = '{1'b1, X, 8'h22, 1'b0, 32'h0,         2'd1, 1'b1, 8'h10, 32'hA1234567,  1'b0};
    vecs[7]  = '{1'b0, X, 8'h23, 1'b1, 32'hBAD0BAD0,  2'd1, 1'b1, 8'h10, 32'hA1234567,  1'b0};
    vecs[8]  = '{1'b0, D, 8'h24, 1'b1, 32'hBAD1BAD1,  2'd1, 1'b1, 8'h10, 32'hA1234567,  1'b0};
    vecs[9]  = '{1'b1, X, 8'h25, 1'b0, 32'h0,         2'd1, 1'b1, 8'h10, 32'hA1234567,  1'b0};
    vecs[10] = '{1'b1, X, 8'h26, 1'b1, 32'hCAFEF00D,  2'd2, 1'b0, 8'h10, 32'hCAFEF00D,  1'b0};
    vecs[11] = '{1'b1, D, 8'h27, 1'b0, 32'h0,         2'd0, 1'b0, 8'h10, 32'hCAFEF00D,  1'b0};

    repeat (2) @(negedge clk);
    chk_all("in_reset", 2'd0, 1'b0, 8'h0, 32'h0, 1'b0);
    rst = 1'b1;
    step(1'b1, X, 8'h00, 1'b0, 32'h0);
    chk_all("after_reset", 2'd0, 1'b0, 8'h0, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].st, vecs[i].pc, vecs[i].rdy, vecs[i].data);
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_valid, vecs[i].e_addr,
              vecs[i].e_instr, vecs[i].e_err);
    end

    begin : timeout_seq
      int n = 0;
      step(1'b1, F, 8'h3C, 1'b0, 32'h0);
      while (mem_read_valid && n < 50) begin
        n++;
        step(1'b1, X, 8'(n), 1'b0, 32'h0);
      end
      chk("timeout_valid_cycles", 64'(n), 64'(TO));
      chk_all("timeout_done", 2'd2, 1'b0, 8'h3C, RET_WORD, 1'b1);
      step(1'b1, D, 8'h00, 1'b0, 32'h0);
      chk_all("timeout_idle", 2'd0, 1'b0, 8'h3C, RET_WORD, 1'b1);
      step(1'b1, F, 8'h41, 1'b0, 32'h0);
      chk_all("refetch_clears_err", 2'd1, 1'b1, 8'h41, RET_WORD, 1'b0);
      step(1'b1, X, 8'h00, 1'b1, 32'h13572468);
      step(1'b1, D, 8'h00, 1'b0, 32'h0);
    end

    begin : tie_seq
      step(1'b1, F, 8'h50, 1'b0, 32'h0);
      for (int i = 0; i < TO - 1; i++) step(1'b1, X, 8'h00, 1'b0, 32'h0);
      chk_all("tie_pre", 2'd1, 1'b1, 8'h50, 32'h13572468, 1'b0);
      step(1'b1, X, 8'h00, 1'b1, 32'h2468ACE0);
      chk_all("tie_ready_wins", 2'd2, 1'b0, 8'h50, 32'h2468ACE0, 1'b0);
      step(1'b1, D, 8'h00, 1'b0, 32'h0);
    end

    begin : async_reset_seq
      step(1'b1, F, 8'h77, 1'b0, 32'h0);
      chk("pre_reset_valid", 64'(mem_read_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_valid", 64'(mem_read_valid), 64'd0);
      chk("async_reset_state", 64'(fetcher_state), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      chk_all("post_reset", 2'd0, 1'b0, 8'h0, 32'h0, 1'b0);
    end

    for (int c = 0; c < 600; c++) begin
      logic [2:0] s;
      int pick;
      pick = $urandom_range(0, 3);
      s = (pick == 0) ? F : (pick == 1) ? D : 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) != 0, s, 8'($urandom), $urandom_range(0, 4) == 0, $urandom);
      chk_all($sformatf("rand%0d", c), 2'(m_phase), m_phase == 1, m_addr, m_instr, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/simd_fetcher.md
# simd_fetcher

Instruction fetch stage for one SIMD core, directly upstream of the decoder. When the core's SIMD state machine enters the fetch state, the block issues a single read request for the current PC to the program-memory controller. It holds the request under a valid/ready handshake and latches the returned instruction word. The word stays stable on `instruction` through the decode state. A bounded wait counter turns a hung memory access into a forced RET so the thread terminates instead of stalling.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, width of the PC and the program-memory address
- INSTRUCTION_WIDTH, 32, width of the instruction word
- TIMEOUT_CYCLES, 255, maximum REQUEST-state cycles before abort; must be ≥1 and < 2^16
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset (0 = in reset)
- enable  input  1  core/block enable; when 0 all registers hold
- simd_state  input  3  core state; only `SIMD_FETCH and `SIMD_DECODE are acted on
- pc  input  PROGRAM_MEM_ADDR_BITS  address of the next instruction
- mem_read_valid  output  1  read request to the program-memory controller
- mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address, latched from pc
- mem_read_ready  input  1  controller response strobe; data is valid in the same cycle
- mem_read_data  input  INSTRUCTION_WIDTH  returned instruction word
- instruction  output  INSTRUCTION_WIDTH  latched instruction, fed to the decoder
- fetcher_state  output  2  IDLE=0, REQUEST=1, DONE=2 (3 unused)
- fetch_error  output  1  last fetch aborted by timeout

## Operation
- All outputs and state are registers; no combinational path from inputs to outputs.
- rst=0 forces these values immediately, regardless of clk: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, fetch_error=0, wait counter=0.
- enable=0: every register holds its value, including a mid-handshake mem_read_valid=1. mem_read_ready is ignored while enable=0.
- IDLE, with enable=1 and simd_state==`SIMD_FETCH:
  - mem_read_address<=pc, mem_read_valid<=1, wait counter<=0, fetch_error<=0
  - go to REQUEST
- IDLE, any other simd_state: stay; instruction retains the previous word.
- REQUEST, mem_read_ready=1:
  - instruction<=mem_read_data, mem_read_valid<=0
  - go to DONE
- REQUEST, mem_read_ready=0, counter==TIMEOUT_CYCLES-1:
  - instruction<={`OP_RET, zeros}, mem_read_valid<=0, fetch_error<=1
  - go to DONE
- REQUEST, mem_read_ready=0, otherwise: counter<=counter+1.
- Counter is 16 bits and unsigned; it never wraps because the abort fires first.
- If ready and the timeout coincide in the same cycle, ready wins: the data is latched and fetch_error stays 0.
- DONE: instruction is held stable. Go to IDLE when simd_state==`SIMD_DECODE; otherwise stay.
- fetch_error stays set until the next fetch starts or reset.
- pc changes while in REQUEST or DONE are ignored; mem_read_address keeps the latched value.
- mem_read_ready in IDLE or DONE is ignored, and mem_read_data is not sampled.

## Timing
- Cycle N: IDLE with `SIMD_FETCH sampled. Cycle N+1: REQUEST, mem_read_valid=1, address valid.
- Ready sampled high at the end of cycle N+k (k≥1) → cycle N+k+1: DONE, instruction valid, mem_read_valid=0.
- Minimum fetch latency: 2 cycles from the `SIMD_FETCH sample to instruction valid.
- Timeout: mem_read_valid is high for exactly TIMEOUT_CYCLES cycles, then DONE with fetch_error=1.
- mem_read_valid and mem_read_address are stable from request start until the ready cycle; the controller may rely on this.
- DONE→IDLE takes 1 cycle after `SIMD_DECODE is sampled. instruction is unchanged across DONE and IDLE, so the decoder can sample it during decode.
- Back-to-back fetches: IDLE accepts a new `SIMD_FETCH on the cycle after it is entered.
- Reset asserted mid-REQUEST: mem_read_valid drops asynchronously. The controller must tolerate the withdrawn request.

## Test plan
- Reset:
  - rst=0 mid-REQUEST, between clock edges → mem_read_valid=0 and fetcher_state=0 immediately, before the next edge.
  - After release, instruction=0 and fetch_error=0.
- Zero-wait fetch:
  - pc=0x05, `SIMD_FETCH at cycle N, ready=1 with data 0xA1234567 in cycle N+1 → address=0x05 in N+1; instruction=0xA1234567 and state=DONE in N+2.
  - `SIMD_DECODE → IDLE one cycle later, instruction unchanged.
- Wait states with enable toggling:
  - ready arrives after 4 cycles; enable=0 for 2 cycles in between → valid and address held throughout, data latched correctly, no early latch.
  - Ready pulses sent while enable=0 are ignored.
- Timeout:
  - TIMEOUT_CYCLES=8, ready never asserted → valid high for exactly 8 cycles, then instruction={`OP_RET,0}, fetch_error=1.
  - The next fetch clears fetch_error.
- Tie at timeout: ready=1 on the 8th REQUEST cycle → data latched, fetch_error=0.
- Stray inputs:
  - ready=1 in IDLE/DONE and pc changes during REQUEST → no state change and no data capture; address keeps its latched value.
